// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS EX stage: ALU control codes, R-type function
// codes, the MULA sequencer state encoding and the default datapath width.
package mips_alu_pkg;

  localparam int MULA_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_MULA = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULA = 6'h1c;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2a;

  typedef enum logic [1:0] {
    MULA_IDLE = 2'b00,
    MULA_CALC = 2'b01,
    MULA_ACC  = 2'b10,
    MULA_DONE = 2'b11
  } mula_state_e;

endpackage

// File: rtl/shift_add_mult.sv
// Unsigned shift-add multiplier datapath: one partial-product step per cycle,
// with a counter flagging the final iteration.
module shift_add_mult
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = MULA_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH:0]     mcand_i,
  input  logic [WIDTH:0]     mplier_i,
  output logic [2*WIDTH-1:0] partial_o,
  output logic               last_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0] partial_q, partial_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      mcand_d   = {{(WIDTH-1){1'b0}}, mcand_i};
      mplier_d  = mplier_i;
      partial_d = '0;
      cnt_d     = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        partial_d = partial_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
    end
  end

  assign partial_o = partial_q;
  assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mula_sequencer.sv
// Multi-cycle MULA controller: sign-magnitude multiply over WIDTH cycles, then
// commit the signed product into {Hi,Lo} while holding the pipeline stalled.
module mula_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = MULA_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic             Flush,
  input  logic             AccClr,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  mula_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               sign_q, sign_d;

  logic               idle_or_done, accept, step, last;
  logic [WIDTH:0]     opa_ext, opb_ext, mag_a, mag_b;
  logic [2*WIDTH-1:0] partial, product;

  assign idle_or_done = (state_q == MULA_IDLE) || (state_q == MULA_DONE);
  assign accept       = Start && !Flush && idle_or_done;
  assign step         = (state_q == MULA_CALC) && !Flush;

  // One extra bit keeps the magnitude of the most-negative operand exact.
  assign opa_ext = {OpA[WIDTH-1], OpA};
  assign opb_ext = {OpB[WIDTH-1], OpB};
  assign mag_a   = opa_ext[WIDTH] ? -opa_ext : opa_ext;
  assign mag_b   = opb_ext[WIDTH] ? -opb_ext : opb_ext;
  assign product = sign_q ? -partial : partial;

  shift_add_mult #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mult (
    .clk      (CLK),
    .rst_n    (Reset_L),
    .load_i   (accept),
    .step_i   (step),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .partial_o(partial),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    case (state_q)
      MULA_IDLE, MULA_DONE: begin
        if (AccClr) begin
          acc_d = '0;
        end
        if (accept) begin
          sign_d  = OpA[WIDTH-1] ^ OpB[WIDTH-1];
          state_d = MULA_CALC;
        end else begin
          state_d = MULA_IDLE;
        end
      end
      MULA_CALC: begin
        if (Flush) begin
          state_d = MULA_IDLE;
        end else if (last) begin
          state_d = MULA_ACC;
        end
      end
      MULA_ACC: begin
        // A flush here suppresses the commit entirely.
        if (Flush) begin
          state_d = MULA_IDLE;
        end else begin
          acc_d   = acc_q + product;
          state_d = MULA_DONE;
        end
      end
      default: state_d = MULA_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= MULA_IDLE;
      acc_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
    end
  end

  assign Busy  = (state_q == MULA_CALC) || (state_q == MULA_ACC);
  assign Done  = (state_q == MULA_DONE);
  assign Stall = Reset_L && (accept || Busy);
  assign Hi    = acc_q[2*WIDTH-1:WIDTH];
  assign Lo    = acc_q[WIDTH-1:0];

endmodule

// File: tb/tb_mula_sequencer.sv
// Self-checking bench for mula_sequencer: cycle-count reference model plus
// directed scenarios with literal expectations and a randomized soak.
module tb_mula_sequencer;

  logic        CLK = 1'b0;
  logic        Reset_L, Start, Flush, AccClr;
  logic [31:0] OpA, OpB;
  logic        Stall, Busy, Done;
  logic [31:0] Hi, Lo;

  int tests = 0;
  int fails = 0;

  // Reference model: cycles elapsed since acceptance (1..32 multiply, 33 commit,
  // 34 result cycle, 0 idle), the architectural accumulator and pending product.
  int          m_cyc = 0;
  logic [63:0] m_acc = '0;
  logic [63:0] m_pend = '0;
  bit          m_valid = 1'b0;
  int          stall_total = 0;
  int          done_total = 0;

  mula_sequencer #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .Start  (Start),
    .Flush  (Flush),
    .AccClr (AccClr),
    .OpA    (OpA),
    .OpB    (OpB),
    .Stall  (Stall),
    .Busy   (Busy),
    .Done   (Done),
    .Hi     (Hi),
    .Lo     (Lo)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input logic st, input logic fl, input logic clr,
                      input logic [31:0] a, input logic [31:0] b, input logic rl);
    logic exp_busy, exp_done, exp_stall;
    Reset_L = rl;
    Start   = st;
    Flush   = fl;
    AccClr  = clr;
    OpA     = a;
    OpB     = b;
    @(negedge CLK);
    if (m_valid) begin
      exp_busy  = (m_cyc >= 1) && (m_cyc <= 33);
      exp_done  = (m_cyc == 34);
      exp_stall = Reset_L && (exp_busy || (Start && !Flush));
      chk("Stall", 64'(Stall), 64'(exp_stall));
      chk("Busy", 64'(Busy), 64'(exp_busy));
      chk("Done", 64'(Done), 64'(exp_done));
      chk("HiLo", {Hi, Lo}, m_acc);
    end
    if (Stall === 1'b1) stall_total++;
    if (Done === 1'b1) done_total++;
    @(posedge CLK);
    if (!Reset_L) begin
      m_cyc   = 0;
      m_acc   = '0;
      m_valid = 1'b1;
    end else if (m_cyc >= 1 && m_cyc <= 33) begin
      if (Flush) begin
        m_cyc = 0;
      end else if (m_cyc == 33) begin
        m_acc = m_acc + m_pend;
        m_cyc = 34;
      end else begin
        m_cyc++;
      end
    end else if (m_valid) begin
      if (AccClr) m_acc = '0;
      if (Start && !Flush) begin
        m_pend = smul(OpA, OpB);
        m_cyc  = 1;
      end else begin
        m_cyc = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
  endtask

  // Accept one MULA and run until its result cycle (Done expected high now).
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic clr);
    step(1'b1, 1'b0, clr, a, b, 1'b1);
    idle(33);
    chk("done_pulse", 64'(Done), 64'd1);
    $display("[TB] MULA %h * %h -> Hi=%h Lo=%h", a, b, Hi, Lo);
  endtask

  initial begin
    int s0, d0;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("reset_HiLo", {Hi, Lo}, 64'd0);
    chk("reset_Busy", 64'(Busy), 64'd0);
    chk("reset_Done", 64'(Done), 64'd0);
    idle(1);

    // 3 * 5: 34 stall cycles, single Done in cycle 35.
    s0 = stall_total;
    d0 = done_total;
    op(32'd3, 32'd5, 1'b0);
    chk("stall_cycles", 64'(stall_total - s0), 64'd34);
    chk("basic_HiLo", {Hi, Lo}, 64'h0000_0000_0000_000F);
    idle(1);
    chk("done_count", 64'(done_total - d0), 64'd1);

    // Back-to-back: -2*3 then 7*1 started in the DONE cycle.
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    op(32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("neg_HiLo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    op(32'd7, 32'd1, 1'b0);
    chk("b2b_HiLo", {Hi, Lo}, 64'h0000_0000_0000_0001);

    // Most-negative operands.
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    op(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("minneg_sq", {Hi, Lo}, 64'h4000_0000_0000_0000);
    op(32'h8000_0000, 32'd1, 1'b0);
    chk("minneg_acc", {Hi, Lo}, 64'h3FFF_FFFF_8000_0000);

    // Flush in the 10th CALC cycle, then in the ACC cycle.
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    op(32'h0001_0000, 32'h0001_0000, 1'b0);
    chk("flush_setup", {Hi, Lo}, 64'h0000_0001_0000_0000);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 1'b1);
    idle(9);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("flush_calc_Busy", 64'(Busy), 64'd0);
    chk("flush_calc_Stall", 64'(Stall), 64'd0);
    chk("flush_calc_Done", 64'(Done), 64'd0);
    chk("flush_calc_HiLo", {Hi, Lo}, 64'h0000_0001_0000_0000);
    step(1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 1'b1);
    idle(32);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("flush_acc_Busy", 64'(Busy), 64'd0);
    chk("flush_acc_Done", 64'(Done), 64'd0);
    chk("flush_acc_HiLo", {Hi, Lo}, 64'h0000_0001_0000_0000);
    idle(1);

    // AccClr with Start, and AccClr ignored during CALC.
    step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    op(32'hDB97_5310, 32'h8000_0000, 1'b0);
    chk("hi_setup", {Hi, Lo}, 64'h1234_5678_0000_0000);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 32'd6, 32'd7, 1'b1);
    idle(5);
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1);
    idle(25);
    chk("accclr_Done", 64'(Done), 64'd1);
    chk("accclr_HiLo", {Hi, Lo}, 64'd42);

    // Reset in the 20th CALC cycle.
    idle(1);
    step(1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 1'b1);
    idle(19);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("rst_mid_Busy", 64'(Busy), 64'd0);
    chk("rst_mid_Done", 64'(Done), 64'd0);
    chk("rst_mid_Stall", 64'(Stall), 64'd0);
    chk("rst_mid_HiLo", {Hi, Lo}, 64'd0);
    op(32'd2, 32'd2, 1'b0);
    chk("post_rst_HiLo", {Hi, Lo}, 64'd4);

    // Randomized soak checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 11) == 0, rnd_op(), rnd_op(),
           $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
